// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle LSL/LSR/ASR shifter, STEP bits per clock, valid/ready both sides
// Define SEQ_SHIFT_ROTATE_EN to add ROL/ROR; otherwise modes 011/100 report err.
module seq_shift_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5,
    parameter int STEP  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] y_o,
    output logic             of_o,
    output logic             err_o,
    output logic             busy_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] STEP_C  = CW'(STEP);
`ifdef SEQ_SHIFT_ROTATE_EN
    localparam int LW = $clog2(WIDTH);
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic             in_ready_q, busy_q, out_valid_q, of_q, err_q;
    logic [WIDTH-1:0] y_q, w_q, w_d;
    logic [CW-1:0]    rem_q, rem_d, sh, cnt_load;
    logic [2:0]       mode_q;
    logic             sign_q, ill_q, illegal_in;
    logic [AMT_W-1:0] amt;

    assign amt = b_i[AMT_W-1:0];

    generate
        if (AMT_W < WIDTH) begin : g_unused
            logic unused_b;
            assign unused_b = ^b_i[WIDTH-1:AMT_W];
        end
    endgenerate

    // Plain shifts saturate at WIDTH steps, which naturally yields 0 or all sign copies.
    always_comb begin
        illegal_in = 1'b0;
        cnt_load   = '0;
        case (mode_i)
            3'b000, 3'b001, 3'b010:
                cnt_load = (32'(amt) >= 32'(WIDTH)) ? WIDTH_C : CW'(amt);
`ifdef SEQ_SHIFT_ROTATE_EN
            3'b011, 3'b100:
                cnt_load = CW'(amt[LW-1:0]);
`endif
            default: illegal_in = 1'b1;
        endcase
    end

    assign sh    = (rem_q > STEP_C) ? STEP_C : rem_q;
    assign rem_d = rem_q - sh;

    always_comb begin
        w_d = w_q;
        case (mode_q)
            3'b000: w_d = w_q << sh;
            3'b001: w_d = w_q >> sh;
            3'b010: w_d = $unsigned($signed(w_q) >>> sh);
`ifdef SEQ_SHIFT_ROTATE_EN
            3'b011: w_d = (w_q << sh) | (w_q >> (WIDTH_C - sh));
            3'b100: w_d = (w_q >> sh) | (w_q << (WIDTH_C - sh));
`endif
            default: w_d = w_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            of_q        <= 1'b0;
            err_q       <= 1'b0;
            w_q         <= '0;
            rem_q       <= '0;
            mode_q      <= '0;
            sign_q      <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        w_q        <= a_i;
                        sign_q     <= a_i[WIDTH-1];
                        mode_q     <= mode_i;
                        ill_q      <= illegal_in;
                        rem_q      <= cnt_load;
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (rem_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        w_q   <= w_d;
                        rem_q <= rem_d;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; afterwards wait for the consumer.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        y_q         <= w_q;
                        of_q        <= ill_q ? 1'b0 : (sign_q ^ w_q[WIDTH-1]);
                        err_q       <= ill_q;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign busy_o      = busy_q;
    assign out_valid_o = out_valid_q;
    assign y_o         = y_q;
    assign of_o        = of_q;
    assign err_o       = err_q;
endmodule
